// File: rtl/operand_fetch_unit.sv
// Operand fetch front end: register-file read select, writeback bypass,
// destination scoreboard with RAW/WAW hazard stall, and a registered operand stage.
module operand_fetch_unit #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   in_src0,
  input  logic [3:0]   in_src1,
  input  logic         in_use0,
  input  logic         in_use1,
  input  logic [3:0]   in_dest,
  input  logic         in_wr,
  output logic [3:0]   rf_source0,
  output logic [3:0]   rf_source1,
  input  logic [W-1:0] rf_output0,
  input  logic [W-1:0] rf_output1,
  input  logic         wb_en,
  input  logic [3:0]   wb_dest,
  input  logic [W-1:0] wb_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_op0,
  output logic [W-1:0] out_op1,
  output logic [3:0]   out_dest,
  output logic         out_wr,
  output logic [14:0]  pending,
  output logic         stall
);

  localparam int unsigned NREG = 15;
  localparam logic [3:0]  R15  = 4'd15;

  logic [15:0]     pend_ext;
  logic            raw0;
  logic            raw1;
  logic            waw;
  logic            hazard;
  logic            accept;
  logic [W-1:0]    byp0;
  logic [W-1:0]    byp1;
  logic [NREG-1:0] set_mask;
  logic [NREG-1:0] clr_mask;
  logic [NREG-1:0] pending_next;

  assign rf_source0 = in_src0;
  assign rf_source1 = in_src1;

  // R15 maps onto a constant-zero scoreboard bit, so it can never hazard.
  always_comb begin
    pend_ext     = {1'b0, pending};
    raw0         = in_use0 && pend_ext[in_src0] && !(wb_en && wb_dest == in_src0);
    raw1         = in_use1 && pend_ext[in_src1] && !(wb_en && wb_dest == in_src1);
    waw          = in_wr && pend_ext[in_dest] && !(wb_en && wb_dest == in_dest);
    hazard       = raw0 || raw1 || waw;
    in_ready     = !reset && !hazard && (!out_valid || out_ready);
    stall        = in_valid && hazard;
    accept       = in_valid && in_ready;
    byp0         = (wb_en && wb_dest == in_src0 && in_src0 != R15) ? wb_data : rf_output0;
    byp1         = (wb_en && wb_dest == in_src1 && in_src1 != R15) ? wb_data : rf_output1;
    set_mask     = '0;
    clr_mask     = '0;
    for (int i = 0; i < int'(NREG); i++) begin
      set_mask[i] = accept && in_wr && (in_dest == 4'(i));
      clr_mask[i] = wb_en && (wb_dest == 4'(i));
    end
    // A same-cycle set beats the clear: the new writer is still in flight.
    pending_next = (pending & ~clr_mask) | set_mask;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_op0   <= '0;
      out_op1   <= '0;
      out_dest  <= '0;
      out_wr    <= 1'b0;
      pending   <= '0;
    end else begin
      pending <= pending_next;
      if (accept) begin
        out_valid <= 1'b1;
        out_op0   <= byp0;
        out_op1   <= byp1;
        out_dest  <= in_dest;
        out_wr    <= in_wr;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
